rr_decoder_sequencer: RTL and testbench

//  Upstream stage of the 2-to-4 structural decoder. Arbitrates 4 request lines round-robin
//  and drives the decoder's enable/addr0/addr1 so exactly one decoder output asserts per grant.

---
 rtl/decoder_pkg.sv | 11 +
 rtl/rr_priority_pick.sv | 25 ++
 rtl/rr_decoder_sequencer.sv | 99 +++++++++
 tb/tb_rr_decoder_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and sizes for the round-robin sequencer that feeds the 2-to-4 decoder.
package decoder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int N_OUT  = 4;
  localparam int ADDR_W = 2;
endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: the first set request at or after (last+1) mod 4 wins.
module rr_priority_pick
  import decoder_pkg::*;
(
  input  logic [N_OUT-1:0]  req,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] pick,
  output logic              any
);
  logic [ADDR_W-1:0] w_idx;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_idx = '0;
    // Offset N_OUT wraps to the previous owner, so it is considered last.
    for (int k = 1; k <= N_OUT; k++) begin
      w_idx = last + ADDR_W'(k);
      if (!any && req[w_idx]) begin
        pick = w_idx;
        any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_decoder_sequencer.sv
// Round-robin grant sequencer driving decoder enable/addr0/addr1 with a one-cycle gap.
// Optional hold timeout is enabled by defining RR_TIMEOUT_EN.
module rr_decoder_sequencer
  import decoder_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_OUT-1:0] req,
  input  logic             done,
  output logic             enable,
  output logic             addr0,
  output logic             addr1,
  output logic             timeout
);
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] w_pick;
  logic              w_any;
  logic              r_enable;
  logic              w_release;
  logic              w_tmo;

  if (HOLD_MAX < 1 || HOLD_MAX > 7 || (1 << CNT_W) <= HOLD_MAX) begin : g_bad_cfg
    $error("rr_decoder_sequencer: HOLD_MAX must be 1..7 and fit in CNT_W bits");
  end

  rr_priority_pick u_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_tmo = (r_cnt == CNT_W'(HOLD_MAX));

  // Counter saturates at HOLD_MAX because reaching it forces the release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == ST_GRANT) && w_tmo;
      if (r_state == ST_IDLE && w_any)
        r_cnt <= CNT_W'(1);
      else if (r_state == ST_GRANT && !w_release)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign timeout = r_timeout;
`else
  assign w_tmo   = 1'b0;
  assign timeout = 1'b0;
`endif

  assign w_release = done | ~req[r_addr] | w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_next = ST_GRANT;
      ST_GRANT:   if (w_release) w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Address is only reloaded on a new pick so it stays frozen through GRANT and RELEASE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_addr   <= '0;
      r_last   <= ADDR_W'(N_OUT - 1);
    end else if (r_state == ST_IDLE && w_any) begin
      r_addr   <= w_pick;
      r_enable <= 1'b1;
    end else if (r_state == ST_GRANT && w_release) begin
      r_enable <= 1'b0;
      r_last   <= r_addr;
    end
  end

  assign enable         = r_enable;
  assign {addr0, addr1} = r_addr;
endmodule

// File: tb/tb_rr_decoder_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rr_decoder_sequencer;
  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       enable, addr0, addr1, timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: who owns the decoder, gap cycle, rotation pointer.
  bit m_en, m_gap, m_tmo;
  int m_addr, m_last, m_hold;

  rr_decoder_sequencer #(.HOLD_MAX(HOLD_MAX), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .enable  (enable),
    .addr0   (addr0),
    .addr1   (addr1),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dec_out(input logic en, input logic a0, input logic a1);
    return en ? (4'b0001 << {a0, a1}) : 4'b0000;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_gap = 0; m_tmo = 0; m_addr = 0; m_last = 3; m_hold = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic d);
    bit tmo_n, tmo;
    tmo_n = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_en) begin
`ifdef RR_TIMEOUT_EN
      tmo = (m_hold == HOLD_MAX);
`else
      tmo = 0;
`endif
      if (d || !r[m_addr] || tmo) begin
        m_en = 0; m_last = m_addr; m_gap = 1; tmo_n = tmo;
      end else if (m_hold < HOLD_MAX) begin
        m_hold++;
      end
    end else if (r != 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_en && r[(m_last + k) % 4]) begin
          m_addr = (m_last + k) % 4; m_en = 1; m_hold = 1;
        end
      end
    end
    m_tmo = tmo_n;
  endtask

  task automatic check_outputs();
    logic [3:0] d;
    d = dec_out(enable, addr0, addr1);
    chk("enable", enable, m_en);
    chk("addr", {addr0, addr1}, m_addr);
    chk("timeout", timeout, m_tmo);
    chk("dec_out", d, m_en ? (1 << m_addr) : 0);
    chk("onehot", ($countones(d) <= 1), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(req, done);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = 4'b0000; done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_addr", {addr0, addr1}, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset pulse placed mid-cycle to exercise the asynchronous clear.
  task automatic async_reset_pulse();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_enable", enable, 0);
    chk("arst_addr", {addr0, addr1}, 0);
    chk("arst_dec", dec_out(enable, addr0, addr1), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic get_grant(output int a);
    int n;
    n = 0;
    while (!enable && n < 8) begin
      step();
      n++;
    end
    if (!enable) chk("grant_wait", 0, 1);
    a = {addr0, addr1};
  endtask

  task automatic release_grant();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    int a, cnt;
    int order3 [5] = '{0, 1, 2, 3, 0};

    model_reset();
    do_reset();

    // Reset in the middle of a grant.
    req = 4'b1111;
    get_grant(a);
    chk("pre_rst_grant", a, 0);
    step();
    async_reset_pulse();
    req = 4'b0000;
    step();

    // Single requester 2, done after two enabled cycles.
    do_reset();
    req = 4'b0100;
    step();
    chk("t2_addr", {addr0, addr1}, 2);
    chk("t2_dec_c1", dec_out(enable, addr0, addr1), 4'b0100);
    step();
    chk("t2_dec_c2", dec_out(enable, addr0, addr1), 4'b0100);
    release_grant();
    chk("t2_gap", dec_out(enable, addr0, addr1), 0);
    req = 4'b0000;
    step();

    // All requesters held: strict rotation with wrap.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      get_grant(a);
      chk("t3_order", a, order3[i]);
      release_grant();
    end
    req = 4'b0000;
    step();

    // Requesters 0 and 3 from reset pointer: 0 first, then 3.
    do_reset();
    req = 4'b1001;
    get_grant(a);
    chk("t4_first", a, 0);
    release_grant();
    get_grant(a);
    chk("t4_second", a, 3);
    release_grant();
    req = 4'b0000;
    step();

    // Held request with no done.
    do_reset();
    req = 4'b0010;
    get_grant(a);
    chk("t5_grant", a, 1);
`ifdef RR_TIMEOUT_EN
    cnt = 1;
    while (cnt < 20) begin
      step();
      if (!enable) break;
      cnt++;
    end
    chk("t5_hold_len", cnt, HOLD_MAX);
    chk("t5_tmo_pulse", timeout, 1);
    step();
    chk("t5_tmo_clear", timeout, 0);
    step();
    chk("t5_regrant", enable, 1);
    chk("t5_regrant_addr", {addr0, addr1}, 1);
`else
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (enable) cnt++;
    end
    chk("t5_unbounded", cnt, 11);
`endif
    req = 4'b0000;
    step();
    step();

    // Granted request dropped without done.
    do_reset();
    req = 4'b0100;
    get_grant(a);
    step();
    req = 4'b0000;
    step();
    chk("t6_drop_en", enable, 0);
    chk("t6_drop_tmo", timeout, 0);
    step();

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      req  = 4'($urandom);
      done = ($urandom_range(3) == 0);
      step();
      if ($urandom_range(99) == 0) async_reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
